// File: rtl/setup_pkg.sv
// setup_pkg: shared types and constants for the keypad door lock.
//   pinPac_t   - one PIN slot: enable flag plus four BCD digits (digit1 is entered first)
//   setupPac_t - full configuration record exchanged with the setup block
//   bcdPac_t   - six-digit BCD display bundle, BCD0 is the rightmost digit
package setup_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hF;
    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef struct packed {
        logic       status;
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
    } pinPac_t;

    typedef struct packed {
        logic       bip_status;
        logic [6:0] bip_time;
        logic [6:0] tranc_aut_time;
        pinPac_t    master_pin;
        pinPac_t    pin1;
        pinPac_t    pin2;
        pinPac_t    pin3;
        pinPac_t    pin4;
        logic       first_boot;
    } setupPac_t;

    typedef struct packed {
        logic [3:0] BCD5;
        logic [3:0] BCD4;
        logic [3:0] BCD3;
        logic [3:0] BCD2;
        logic [3:0] BCD1;
        logic [3:0] BCD0;
    } bcdPac_t;

    // Factory configuration: master 1234 enabled, user PINs off, first boot pending.
    function automatic setupPac_t setup_default();
        setupPac_t c;
        c                = '0;
        c.bip_status     = 1'b1;
        c.bip_time       = 7'd5;
        c.tranc_aut_time = 7'd5;
        c.master_pin     = '{status: 1'b1, digit1: 4'd1, digit2: 4'd2, digit3: 4'd3, digit4: 4'd4};
        c.first_boot     = 1'b1;
        return c;
    endfunction

    // Digit comparison only; the enable flag is judged by the caller.
    function automatic logic pin_digits_eq(pinPac_t a, pinPac_t b);
        return {a.digit1, a.digit2, a.digit3, a.digit4} == {b.digit1, b.digit2, b.digit3, b.digit4};
    endfunction

endpackage

// File: rtl/operacional_pin_buffer.sv
// pin_buffer: 4-digit keypad entry buffer.
//   i_shift/i_digit - shift a new digit in (newest lands in BCD0)
//   i_clear         - blank the buffer and zero the digit count
//   o_entry         - buffered PIN; status=1 once four digits have been entered
//   o_bcd           - display packing, unused positions blank
module pin_buffer
    import setup_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_shift,
    input  logic [3:0] i_digit,
    input  logic       i_clear,
    output pinPac_t    o_entry,
    output bcdPac_t    o_bcd
);

    logic [3:0][3:0] r_dig;    // [0] newest ... [3] oldest
    logic [2:0]      r_count;  // saturates at 4

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dig   <= {4{BCD_BLANK}};
            r_count <= '0;
        end else if (i_clear) begin
            r_dig   <= {4{BCD_BLANK}};
            r_count <= '0;
        end else if (i_shift) begin
            r_dig <= {r_dig[2:0], i_digit};
            if (r_count != 3'd4)
                r_count <= r_count + 3'd1;
        end
    end

    always_comb begin
        o_entry.status = (r_count == 3'd4);
        o_entry.digit1 = r_dig[3];
        o_entry.digit2 = r_dig[2];
        o_entry.digit3 = r_dig[1];
        o_entry.digit4 = r_dig[0];
        o_bcd.BCD0     = r_dig[0];
        o_bcd.BCD1     = r_dig[1];
        o_bcd.BCD2     = r_dig[2];
        o_bcd.BCD3     = r_dig[3];
        o_bcd.BCD4     = BCD_BLANK;
        o_bcd.BCD5     = BCD_BLANK;
    end

endmodule

// File: rtl/operacional.sv
// operacional: operational controller of the keypad door lock.
//   clk, rst            - clock, asynchronous active-low reset
//   sensor_de_contato   - door contact (1 = closed)
//   botao_interno       - inside button pulse; toggles locked/unlocked
//   key_valid, key_code - keypad strobe and code (0-9, F enter, E clear)
//   setup_end           - setup block finished; data_setup_new is latched
//   bcd_out, bcd_enable - 6-digit display and its enable
//   tranca, bip         - lock actuator (1 = locked) and open-door beeper
//   setup_on            - high while the setup block owns the keypad
//   data_setup_old      - active configuration record
module operacional
    import setup_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int MAX_FAILS     = 3,
    parameter int LOCKOUT_SEC   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_de_contato,
    input  logic       botao_interno,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       setup_end,
    input  setupPac_t  data_setup_new,
    output bcdPac_t    bcd_out,
    output logic       bcd_enable,
    output logic       tranca,
    output logic       bip,
    output logic       setup_on,
    output setupPac_t  data_setup_old
);

    typedef enum logic [2:0] {
        TRAVADO, NOVA_MASTER, DESTRAVADO, PORTA_ABERTA, SETUP, BLOQUEADO
    } state_t;

    localparam int             TW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0]  TICK_MAX   = TW'(TICKS_PER_SEC - 1);
    localparam logic [7:0]     LOCK_LIMIT = 8'(LOCKOUT_SEC);

    state_t          r_state, w_state_nxt;
    setupPac_t       r_cfg, w_cfg_nxt;
    logic [7:0]      r_fails, w_fails_nxt;
    logic [TW-1:0]   r_tick;
    logic [7:0]      r_sec;
    logic            r_bip;
    logic            r_bcd_en;

    pinPac_t         w_entry;
    bcdPac_t         w_buf_bcd;
    logic            w_key_act, w_digit, w_enter, w_clear_key, w_buf_clr;
    logic            w_full, w_master_ok, w_user_ok, w_match;
    logic            w_tick_wrap, w_elapsed;
    logic [8:0]      w_secs_next;
    logic [7:0]      w_limit;

    // The button has priority: a key arriving with it is discarded.
    assign w_key_act   = key_valid && !botao_interno && (r_state != SETUP) && (r_state != BLOQUEADO);
    assign w_digit     = w_key_act && (key_code <= 4'd9);
    assign w_enter     = w_key_act && (key_code == KEY_ENTER);
    assign w_clear_key = w_key_act && (key_code == KEY_CLEAR);
    assign w_buf_clr   = w_enter || w_clear_key;

    pin_buffer u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_shift (w_digit),
        .i_digit (key_code),
        .i_clear (w_buf_clr),
        .o_entry (w_entry),
        .o_bcd   (w_buf_bcd)
    );

    assign w_full      = w_entry.status;
    assign w_master_ok = w_full && pin_digits_eq(w_entry, r_cfg.master_pin);
    assign w_user_ok   = w_full && ((r_cfg.pin1.status && pin_digits_eq(w_entry, r_cfg.pin1)) ||
                                    (r_cfg.pin2.status && pin_digits_eq(w_entry, r_cfg.pin2)) ||
                                    (r_cfg.pin3.status && pin_digits_eq(w_entry, r_cfg.pin3)) ||
                                    (r_cfg.pin4.status && pin_digits_eq(w_entry, r_cfg.pin4)));
    assign w_match     = w_master_ok || w_user_ok;

    // Seconds timer restarts on every state change. w_elapsed looks one cycle
    // ahead so the transition lands exactly limit*TICKS_PER_SEC edges after entry.
    always_comb begin
        w_limit = 8'hFF;
        case (r_state)
            DESTRAVADO:   w_limit = {1'b0, r_cfg.tranc_aut_time};
            PORTA_ABERTA: w_limit = {1'b0, r_cfg.bip_time};
            BLOQUEADO:    w_limit = LOCK_LIMIT;
            default:      w_limit = 8'hFF;
        endcase
    end

    assign w_tick_wrap = (r_tick == TICK_MAX);
    assign w_secs_next = {1'b0, r_sec} + {8'd0, w_tick_wrap};
    assign w_elapsed   = (w_secs_next >= {1'b0, w_limit});

    always_comb begin
        w_state_nxt = r_state;
        w_fails_nxt = r_fails;
        w_cfg_nxt   = r_cfg;
        case (r_state)
            TRAVADO: begin
                if (botao_interno) begin
                    w_state_nxt = DESTRAVADO;
                end else if (w_enter) begin
                    if (w_match) begin
                        w_fails_nxt = '0;
                        w_state_nxt = r_cfg.first_boot ? NOVA_MASTER : DESTRAVADO;
                    end else begin
                        w_fails_nxt = r_fails + 8'd1;
                        if (int'(r_fails) + 1 >= MAX_FAILS)
                            w_state_nxt = BLOQUEADO;
                    end
                end
            end
            NOVA_MASTER: begin
                // A short entry leaves us waiting for a full 4-digit PIN.
                if (w_enter && w_full) begin
                    w_cfg_nxt.master_pin = w_entry;
                    w_cfg_nxt.first_boot = 1'b0;
                    w_state_nxt          = DESTRAVADO;
                end
            end
            DESTRAVADO: begin
                if (!sensor_de_contato)
                    w_state_nxt = PORTA_ABERTA;
                else if (botao_interno)
                    w_state_nxt = TRAVADO;
                else if (w_enter && w_master_ok)
                    w_state_nxt = SETUP;
                else if (w_elapsed)
                    w_state_nxt = TRAVADO;
            end
            PORTA_ABERTA: begin
                if (sensor_de_contato)
                    w_state_nxt = DESTRAVADO;
            end
            SETUP: begin
                if (setup_end) begin
                    w_cfg_nxt   = data_setup_new;
                    w_state_nxt = DESTRAVADO;
                end
            end
            BLOQUEADO: begin
                if (w_elapsed) begin
                    w_fails_nxt = '0;
                    w_state_nxt = TRAVADO;
                end
            end
            default: w_state_nxt = TRAVADO;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= TRAVADO;
            r_cfg    <= setup_default();
            r_fails  <= '0;
            r_tick   <= '0;
            r_sec    <= '0;
            r_bip    <= 1'b0;
            r_bcd_en <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cfg   <= w_cfg_nxt;
            r_fails <= w_fails_nxt;

            if (w_state_nxt != r_state) begin
                r_tick <= '0;
                r_sec  <= '0;
            end else begin
                r_tick <= w_tick_wrap ? '0 : r_tick + TW'(1);
                if (w_tick_wrap && (r_sec != 8'hFF))
                    r_sec <= r_sec + 8'd1;
            end

            // Beeper latches once the open-door delay expires; drops as soon
            // as the door leaves PORTA_ABERTA.
            r_bip <= (w_state_nxt == PORTA_ABERTA) &&
                     (r_bip || ((r_state == PORTA_ABERTA) && w_elapsed && r_cfg.bip_status));

            if (w_digit)
                r_bcd_en <= 1'b1;
            else if (w_buf_clr)
                r_bcd_en <= 1'b0;
        end
    end

    always_comb begin
        tranca         = !((r_state == DESTRAVADO) || (r_state == PORTA_ABERTA) || (r_state == SETUP));
        setup_on       = (r_state == SETUP);
        bip            = r_bip;
        data_setup_old = r_cfg;
        if (r_state == BLOQUEADO) begin
            bcd_out    = '0;
            bcd_enable = 1'b1;
        end else begin
            bcd_out    = w_buf_bcd;
            bcd_enable = r_bcd_en;
        end
    end

endmodule

// File: tb/tb_operacional.sv
module tb_operacional;
    import setup_pkg::*;

    localparam int TPS = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensor_de_contato;
    logic       botao_interno;
    logic       key_valid;
    logic [3:0] key_code;
    logic       setup_end;
    setupPac_t  data_setup_new;
    bcdPac_t    bcd_out;
    logic       bcd_enable;
    logic       tranca;
    logic       bip;
    logic       setup_on;
    setupPac_t  data_setup_old;

    operacional #(.TICKS_PER_SEC(TPS), .MAX_FAILS(3), .LOCKOUT_SEC(10)) dut (
        .clk               (clk),
        .rst               (rst),
        .sensor_de_contato (sensor_de_contato),
        .botao_interno     (botao_interno),
        .key_valid         (key_valid),
        .key_code          (key_code),
        .setup_end         (setup_end),
        .data_setup_new    (data_setup_new),
        .bcd_out           (bcd_out),
        .bcd_enable        (bcd_enable),
        .tranca            (tranca),
        .bip               (bip),
        .setup_on          (setup_on),
        .data_setup_old    (data_setup_old)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int        n_cmp = 0;
    int        n_bad = 0;
    int        t_unlock;
    setupPac_t exp_cfg;

    // ---------------- reference model ----------------
    function automatic logic [15:0] digits_of(input pinPac_t p);
        return {p.digit1, p.digit2, p.digit3, p.digit4};
    endfunction

    function automatic bit accepted(input setupPac_t c, input logic [15:0] ds);
        return (ds == digits_of(c.master_pin)) ||
               (c.pin1.status && ds == digits_of(c.pin1)) ||
               (c.pin2.status && ds == digits_of(c.pin2)) ||
               (c.pin3.status && ds == digits_of(c.pin3)) ||
               (c.pin4.status && ds == digits_of(c.pin4));
    endfunction

    function automatic setupPac_t factory_cfg();
        setupPac_t c;
        c                = '0;
        c.bip_status     = 1'b1;
        c.bip_time       = 7'd5;
        c.tranc_aut_time = 7'd5;
        c.master_pin     = {1'b1, 4'd1, 4'd2, 4'd3, 4'd4};
        c.first_boot     = 1'b1;
        return c;
    endfunction

    function automatic logic [15:0] rand_wrong(input setupPac_t c);
        logic [15:0] ds;
        ds = 16'h0000;
        for (int t = 0; t < 100; t++) begin
            ds = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if (!accepted(c, ds)) break;
        end
        return ds;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic press(input logic [3:0] k);
        if ($urandom_range(0, 1) == 1) step();
        key_code  = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic enter_pin(input logic [15:0] ds);
        for (int i = 3; i >= 0; i--) press(ds[i*4 +: 4]);
        press(KEY_ENTER);
    endtask

    task automatic pulse_button();
        botao_interno = 1'b1;
        step();
        botao_interno = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        exp_cfg = factory_cfg();
        n_cmp++; if (tranca !== 1'b1) begin n_bad++; $display("FAIL reset_tranca got %b want 1", tranca); end
        n_cmp++; if (bip !== 1'b0) begin n_bad++; $display("FAIL reset_bip got %b want 0", bip); end
        n_cmp++; if (setup_on !== 1'b0) begin n_bad++; $display("FAIL reset_setup_on got %b want 0", setup_on); end
        n_cmp++; if (bcd_enable !== 1'b0) begin n_bad++; $display("FAIL reset_bcd_enable got %b want 0", bcd_enable); end
        n_cmp++; if (bcd_out !== 24'hFFFFFF) begin n_bad++; $display("FAIL reset_bcd got %h want ffffff", bcd_out); end
        n_cmp++; if (data_setup_old !== exp_cfg) begin n_bad++; $display("FAIL reset_cfg got %h want %h", data_setup_old, exp_cfg); end
    endtask

    task automatic test_display();
        logic [3:0] q[$];
        bcdPac_t    e;
        logic [3:0] d;
        for (int n = 0; n < 7; n++) begin
            d = 4'($urandom_range(0, 9));
            press(d);
            q.push_back(d);
            if (q.size() > 4) void'(q.pop_front());
            e = 24'hFFFFFF;
            if (q.size() > 0) e.BCD0 = q[q.size()-1];
            if (q.size() > 1) e.BCD1 = q[q.size()-2];
            if (q.size() > 2) e.BCD2 = q[q.size()-3];
            if (q.size() > 3) e.BCD3 = q[q.size()-4];
            n_cmp++; if (bcd_out !== e) begin n_bad++; $display("FAIL display_digit%0d got %h want %h", n, bcd_out, e); end
            n_cmp++; if (bcd_enable !== 1'b1) begin n_bad++; $display("FAIL display_enable%0d got %b want 1", n, bcd_enable); end
        end
        press(4'hA);
        n_cmp++; if (bcd_out !== e) begin n_bad++; $display("FAIL display_ignored_code got %h want %h", bcd_out, e); end
        press(KEY_CLEAR);
        n_cmp++; if (bcd_out !== 24'hFFFFFF) begin n_bad++; $display("FAIL display_clear got %h want ffffff", bcd_out); end
        n_cmp++; if (bcd_enable !== 1'b0) begin n_bad++; $display("FAIL display_clear_en got %b want 0", bcd_enable); end
    endtask

    task automatic test_first_boot();
        enter_pin(16'h1234);
        n_cmp++; if (tranca !== 1'b1) begin n_bad++; $display("FAIL fb_nova_tranca got %b want 1", tranca); end
        n_cmp++; if (bcd_enable !== 1'b0) begin n_bad++; $display("FAIL fb_blank_en got %b want 0", bcd_enable); end
        press(4'd5); press(4'd6); press(KEY_ENTER);
        n_cmp++; if (data_setup_old !== exp_cfg) begin n_bad++; $display("FAIL fb_short_cfg got %h want %h", data_setup_old, exp_cfg); end
        n_cmp++; if (tranca !== 1'b1) begin n_bad++; $display("FAIL fb_short_tranca got %b want 1", tranca); end
        enter_pin(16'h5678);
        t_unlock = cyc;
        exp_cfg.master_pin = {1'b1, 4'd5, 4'd6, 4'd7, 4'd8};
        exp_cfg.first_boot = 1'b0;
        n_cmp++; if (data_setup_old !== exp_cfg) begin n_bad++; $display("FAIL fb_new_master got %h want %h", data_setup_old, exp_cfg); end
        n_cmp++; if (tranca !== 1'b0) begin n_bad++; $display("FAIL fb_unlock got %b want 0", tranca); end
    endtask

    task automatic test_unlocked_ignore();
        enter_pin(16'h0000);
        n_cmp++; if (data_setup_old !== exp_cfg) begin n_bad++; $display("FAIL ign_cfg got %h want %h", data_setup_old, exp_cfg); end
        n_cmp++; if (tranca !== 1'b0 || setup_on !== 1'b0) begin n_bad++; $display("FAIL ign_state got tranca=%b setup_on=%b want 0 0", tranca, setup_on); end
        wait_to(t_unlock + 5 * TPS - 1);
        n_cmp++; if (tranca !== 1'b0) begin n_bad++; $display("FAIL autolock_early got %b want 0", tranca); end
        step();
        n_cmp++; if (tranca !== 1'b1) begin n_bad++; $display("FAIL autolock got %b want 1", tranca); end
    endtask

    task automatic test_door_open();
        int t0;
        enter_pin(16'h5678);
        n_cmp++; if (tranca !== 1'b0) begin n_bad++; $display("FAIL door_unlock got %b want 0", tranca); end
        sensor_de_contato = 1'b0;
        step();
        t0 = cyc;
        wait_to(t0 + 5 * TPS - 1);
        n_cmp++; if (bip !== 1'b0) begin n_bad++; $display("FAIL bip_early got %b want 0", bip); end
        step();
        n_cmp++; if (bip !== 1'b1) begin n_bad++; $display("FAIL bip_on got %b want 1", bip); end
        wait_to(t0 + 6000);
        n_cmp++; if (bip !== 1'b1 || tranca !== 1'b0) begin n_bad++; $display("FAIL bip_hold got bip=%b tranca=%b want 1 0", bip, tranca); end
        sensor_de_contato = 1'b1;
        step();
        t0 = cyc;
        n_cmp++; if (bip !== 1'b0) begin n_bad++; $display("FAIL bip_off got %b want 0", bip); end
        wait_to(t0 + 5 * TPS - 1);
        n_cmp++; if (tranca !== 1'b0) begin n_bad++; $display("FAIL relock_early got %b want 0", tranca); end
        step();
        n_cmp++; if (tranca !== 1'b1) begin n_bad++; $display("FAIL relock got %b want 1", tranca); end
    endtask

    task automatic test_lockout();
        int t0;
        t0 = 0;
        for (int k = 0; k < 3; k++) begin
            enter_pin(rand_wrong(exp_cfg));
            if (k < 2) begin
                n_cmp++; if (bcd_out !== 24'hFFFFFF || bcd_enable !== 1'b0) begin n_bad++; $display("FAIL lock_fail%0d got bcd=%h en=%b want ffffff 0", k, bcd_out, bcd_enable); end
            end else begin
                t0 = cyc;
                n_cmp++; if (bcd_out !== 24'h000000 || bcd_enable !== 1'b1) begin n_bad++; $display("FAIL lockout_enter got bcd=%h en=%b want 000000 1", bcd_out, bcd_enable); end
            end
        end
        enter_pin(16'h5678);
        n_cmp++; if (tranca !== 1'b1 || bcd_out !== 24'h000000) begin n_bad++; $display("FAIL lockout_keys got tranca=%b bcd=%h want 1 000000", tranca, bcd_out); end
        wait_to(t0 + 10 * TPS - 1);
        n_cmp++; if (bcd_enable !== 1'b1) begin n_bad++; $display("FAIL lockout_early got en=%b want 1", bcd_enable); end
        step();
        n_cmp++; if (bcd_out !== 24'hFFFFFF || bcd_enable !== 1'b0 || tranca !== 1'b1) begin n_bad++; $display("FAIL lockout_exit got bcd=%h en=%b tranca=%b want ffffff 0 1", bcd_out, bcd_enable, tranca); end
        enter_pin(rand_wrong(exp_cfg));
        n_cmp++; if (bcd_enable !== 1'b0) begin n_bad++; $display("FAIL fails_cleared got en=%b want 0", bcd_enable); end
        enter_pin(16'h5678);
        n_cmp++; if (tranca !== 1'b0) begin n_bad++; $display("FAIL post_lock_unlock got %b want 0", tranca); end
    endtask

    task automatic test_button();
        pulse_button();
        n_cmp++; if (tranca !== 1'b1) begin n_bad++; $display("FAIL button_lock got %b want 1", tranca); end
        key_code = 4'd7; key_valid = 1'b1; botao_interno = 1'b1;
        step();
        key_valid = 1'b0; botao_interno = 1'b0;
        n_cmp++; if (tranca !== 1'b0 || bcd_enable !== 1'b0) begin n_bad++; $display("FAIL button_wins got tranca=%b en=%b want 0 0", tranca, bcd_enable); end
        pulse_button();
        n_cmp++; if (tranca !== 1'b1) begin n_bad++; $display("FAIL button_relock got %b want 1", tranca); end
    endtask

    task automatic test_setup();
        setupPac_t   rec;
        logic [15:0] p2, p3;
        enter_pin(16'h5678);
        enter_pin(16'h5678);
        n_cmp++; if (setup_on !== 1'b1 || tranca !== 1'b0) begin n_bad++; $display("FAIL setup_enter got setup_on=%b tranca=%b want 1 0", setup_on, tranca); end
        press(4'd3);
        n_cmp++; if (bcd_enable !== 1'b0) begin n_bad++; $display("FAIL setup_keys got en=%b want 0", bcd_enable); end
        p2 = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
        p3 = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
        rec                = exp_cfg;
        rec.pin1           = {1'b1, 16'h9999};
        rec.pin2           = {1'b0, p2};
        rec.pin3           = {1'b1, p3};
        rec.pin4           = {1'b0, 16'h0000};
        data_setup_new = rec;
        setup_end = 1'b1;
        step();
        setup_end = 1'b0;
        exp_cfg = rec;
        n_cmp++; if (setup_on !== 1'b0 || tranca !== 1'b0) begin n_bad++; $display("FAIL setup_exit got setup_on=%b tranca=%b want 0 0", setup_on, tranca); end
        n_cmp++; if (data_setup_old !== exp_cfg) begin n_bad++; $display("FAIL setup_cfg got %h want %h", data_setup_old, exp_cfg); end
        pulse_button();
        enter_pin(p2);
        n_cmp++; if (tranca !== !accepted(exp_cfg, p2)) begin n_bad++; $display("FAIL pin_disabled got %b want %b", tranca, !accepted(exp_cfg, p2)); end
        if (tranca === 1'b0) pulse_button();
        enter_pin(p3);
        n_cmp++; if (tranca !== 1'b0) begin n_bad++; $display("FAIL pin3_unlock got %b want 0", tranca); end
        pulse_button();
        enter_pin(16'h9999);
        n_cmp++; if (tranca !== 1'b0) begin n_bad++; $display("FAIL pin1_unlock got %b want 0", tranca); end
    endtask

    task automatic test_reset_mid();
        press(4'd2);
        rst = 1'b0;
        step();
        exp_cfg = factory_cfg();
        n_cmp++; if (tranca !== 1'b1 || bcd_enable !== 1'b0 || setup_on !== 1'b0 || bip !== 1'b0) begin n_bad++; $display("FAIL midreset_out got tranca=%b en=%b setup_on=%b bip=%b want 1 0 0 0", tranca, bcd_enable, setup_on, bip); end
        n_cmp++; if (data_setup_old !== exp_cfg) begin n_bad++; $display("FAIL midreset_cfg got %h want %h", data_setup_old, exp_cfg); end
        rst = 1'b1;
        step();
        enter_pin(16'h1234);
        n_cmp++; if (tranca !== 1'b1) begin n_bad++; $display("FAIL midreset_nova got %b want 1", tranca); end
        enter_pin(16'h4321);
        exp_cfg.master_pin = {1'b1, 16'h4321};
        exp_cfg.first_boot = 1'b0;
        n_cmp++; if (data_setup_old !== exp_cfg || tranca !== 1'b0) begin n_bad++; $display("FAIL midreset_master got %h tranca=%b want %h 0", data_setup_old, tranca, exp_cfg); end
    endtask

    initial begin
        rst               = 1'b0;
        sensor_de_contato = 1'b1;
        botao_interno     = 1'b0;
        key_valid         = 1'b0;
        key_code          = 4'h0;
        setup_end         = 1'b0;
        data_setup_new    = '0;
        test_reset();
        test_display();
        test_first_boot();
        test_unlocked_ignore();
        test_door_open();
        test_lockout();
        test_button();
        test_setup();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
